// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if
//   Bundles the SPI pins and the word-wide flash read port of the SPI flash
//   responder.
//   slave  : responder view (SPI slave, initiator on the memory port)
//   master : environment view (SPI master pins plus the memory model)
//   Signals: spi_sck/spi_ss/spi_mosi/spi_miso (SPI mode 0, SS active-low),
//            mem_req/mem_addr (level request, word-aligned byte address),
//            mem_ack/mem_rdata (single-cycle ack, little-endian word).
interface spi_flash_responder_if #(
    parameter int ADDR_W = 24
);
    logic              spi_sck;
    logic              spi_ss;
    logic              spi_mosi;
    logic              spi_miso;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  spi_sck, spi_ss, spi_mosi, mem_ack, mem_rdata,
        output spi_miso, mem_req, mem_addr
    );
    modport master (
        output spi_sck, spi_ss, spi_mosi, mem_ack, mem_rdata,
        input  spi_miso, mem_req, mem_addr
    );
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 flash emulator. Decodes READ (0x03) and READ-ID (0x9F) and
//   serves READ data from a word-wide memory port with one-word prefetch.
//   clock    : system clock, all logic on the rising edge
//   reset    : synchronous, active-low
//   bus      : SPI pins + memory read port (slave modport)
//   busy     : transaction in progress or memory request outstanding
//   underrun : sticky, data was needed before memory delivered it;
//              cleared by the next SS fall
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID = 24'hEF4017,
    parameter int          ADDR_W   = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    spi_flash_responder_if.slave bus,
    output logic                 busy,
    output logic                 underrun
);
    localparam int            CW            = $clog2(ADDR_W) + 1;
    localparam logic [CW-1:0] LAST_CMD_BIT  = CW'(7);
    localparam logic [CW-1:0] LAST_ADDR_BIT = CW'(ADDR_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_FETCH, S_DATA, S_ID, S_IGNORE
    } state_t;

    state_t state, state_n;

    logic [1:0]        sck_s, ss_s, mosi_s;
    logic              sck_d, ss_d;
    logic [CW-1:0]     bit_cnt;
    logic [ADDR_W-2:0] shreg;
    logic [23:0]       id_sh;
    logic [1:0]        byte_ptr;
    logic [2:0]        tx_bit;
    logic [31:0]       cur_word, pre_word;
    logic              pre_valid, fetch_pend, stale, miso_q, mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-3:0] next_waddr;

    logic              sck_rise, sck_fall, ss_rise, ss_fall;
    logic [7:0]        cmd_byte;
    logic [ADDR_W-1:0] addr_full;
    logic              cmd_done, addr_done, ack_fire, ack_use, tx_last, pre_ok, issue;
    logic [31:0]       pre_data;
    logic [ADDR_W-3:0] issue_waddr;

    assign sck_rise  = sck_s[1] & ~sck_d;
    assign sck_fall  = ~sck_s[1] & sck_d;
    assign ss_rise   = ss_s[1] & ~ss_d;
    assign ss_fall   = ~ss_s[1] & ss_d;

    // Value including the bit arriving on this rise.
    assign cmd_byte  = {shreg[6:0], mosi_s[1]};
    assign addr_full = {shreg, mosi_s[1]};

    assign cmd_done  = (state == S_CMD)  && sck_rise && (bit_cnt == LAST_CMD_BIT);
    assign addr_done = (state == S_ADDR) && sck_rise && (bit_cnt == LAST_ADDR_BIT) && !ss_rise;

    // Acks for a request issued before the last SS rise are dropped.
    assign ack_fire  = mem_req_q & bus.mem_ack;
    assign ack_use   = ack_fire & ~stale & ~ss_rise & ((state == S_FETCH) | (state == S_DATA));

    // Fall that places the last bit of byte 3: the next fall needs a new word.
    // A prefetch ack landing in that same cycle is forwarded directly.
    assign tx_last   = (state == S_DATA) && sck_fall && (tx_bit == 3'd7) && (byte_ptr == 2'd3);
    assign pre_ok    = pre_valid | (ack_use & (state == S_DATA));
    assign pre_data  = pre_valid ? pre_word : bus.mem_rdata;

    // One outstanding request; a pending fetch waits for mem_req to drop.
    assign issue       = ~mem_req_q & (fetch_pend | addr_done) & ~ss_rise & (state != S_IDLE);
    assign issue_waddr = addr_done ? addr_full[ADDR_W-1:2] : next_waddr;

    assign bus.spi_miso = miso_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign busy         = (state != S_IDLE) | mem_req_q;

    always_ff @(posedge clock) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (ss_rise) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (ss_fall) state_n = S_CMD;
                S_CMD:   if (cmd_done)
                             state_n = (cmd_byte == 8'h03) ? S_ADDR :
                                       (cmd_byte == 8'h9F) ? S_ID : S_IGNORE;
                S_ADDR:  if (addr_done) state_n = S_FETCH;
                S_FETCH: if (ack_use) state_n = S_DATA;
                S_DATA:  if (tx_last && !pre_ok) state_n = S_FETCH;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sck_s      <= '0;
            ss_s       <= '0;   // SS reads as asserted so a low pin after reset is no fall
            mosi_s     <= '0;
            sck_d      <= 1'b0;
            ss_d       <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            id_sh      <= '1;
            byte_ptr   <= '0;
            tx_bit     <= '0;
            cur_word   <= '0;
            pre_word   <= '0;
            pre_valid  <= 1'b0;
            fetch_pend <= 1'b0;
            stale      <= 1'b0;
            miso_q     <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            next_waddr <= '0;
            underrun   <= 1'b0;
        end else begin
            sck_s  <= {sck_s[0], bus.spi_sck};
            ss_s   <= {ss_s[0], bus.spi_ss};
            mosi_s <= {mosi_s[0], bus.spi_mosi};
            sck_d  <= sck_s[1];
            ss_d   <= ss_s[1];

            // Command / address receive
            if (sck_rise && (state == S_CMD || state == S_ADDR)) begin
                shreg   <= {shreg[ADDR_W-3:0], mosi_s[1]};
                bit_cnt <= (cmd_done || addr_done) ? '0 : bit_cnt + CW'(1);
            end
            if (state == S_IDLE) bit_cnt <= '0;
            if (cmd_done) id_sh <= JEDEC_ID;
            if (addr_done) begin
                byte_ptr <= addr_full[1:0];
                tx_bit   <= '0;
            end

            // MISO only moves on SCK falls so a placed bit survives the next rise
            if (state == S_IDLE || ss_rise) begin
                miso_q <= 1'b1;
            end else if (sck_fall) begin
                case (state)
                    S_DATA:  miso_q <= cur_word[{byte_ptr, ~tx_bit}];
                    S_ID:    miso_q <= id_sh[23];
                    default: miso_q <= 1'b1;
                endcase
            end
            if (sck_fall && state == S_ID) id_sh <= {id_sh[22:0], 1'b1};
            if (sck_fall && state == S_DATA) begin
                tx_bit <= tx_bit + 3'd1;
                if (tx_bit == 3'd7) byte_ptr <= byte_ptr + 2'd1;
            end

            // Word buffers
            if (ack_use && state == S_FETCH) cur_word <= bus.mem_rdata;
            if (ack_use && state == S_DATA) begin
                pre_word  <= bus.mem_rdata;
                pre_valid <= 1'b1;
            end
            if (tx_last && pre_ok) begin
                cur_word  <= pre_data;
                pre_valid <= 1'b0;
            end
            if (state == S_IDLE) pre_valid <= 1'b0;

            // Memory request; later assignments take priority
            if (addr_done) begin
                next_waddr <= addr_full[ADDR_W-1:2];
                fetch_pend <= 1'b1;
            end
            if (ack_fire) begin
                mem_req_q <= 1'b0;
                stale     <= 1'b0;
            end else if (issue) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= {issue_waddr, 2'b00};
                next_waddr <= issue_waddr + 1'b1;
                fetch_pend <= 1'b0;
            end
            // Prefetch the following word as soon as a word starts being sent
            if ((ack_use && state == S_FETCH) || (tx_last && pre_ok)) fetch_pend <= 1'b1;
            if (ss_rise && mem_req_q && !ack_fire) stale <= 1'b1;
            if (state == S_IDLE) fetch_pend <= 1'b0;

            if (ss_fall) underrun <= 1'b0;
            else if ((sck_fall && state == S_FETCH) || (tx_last && !pre_ok)) underrun <= 1'b1;
        end
    end
endmodule
